// File: rtl/base_rrarb_pkg.sv
// Shared helpers for the base_* arbiter slice.
package base_rrarb_pkg;

    // Ceiling log2, never less than 1, so a 1-bit index still has a legal width.
    function automatic int unsigned clog2_min1(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/base_rrpick.sv
// Rotating priority pick: first valid index after i_ptr, wrapping, with i_ptr itself checked last.
module base_rrpick
    import base_rrarb_pkg::*;
#(
    parameter int unsigned n   = 4,
    parameter int unsigned idw = clog2_min1(n)
) (
    input  logic [idw-1:0] i_ptr,
    input  logic [n-1:0]   i_v,
    output logic [idw-1:0] o_sel,
    output logic           o_any
);

    logic [idw-1:0] w_idx;
    int unsigned    w_sum;

    // Scan from the farthest candidate down so the nearest valid one wins.
    always_comb begin
        o_sel = i_ptr;
        o_any = |i_v;
        w_idx = '0;
        w_sum = 0;
        for (int unsigned k = n; k >= 1; k--) begin
            w_sum = 32'(i_ptr) + k;
            if (w_sum >= n) w_sum = w_sum - n;
            w_idx = idw'(w_sum);
            if (i_v[w_idx]) o_sel = w_idx;
        end
    end

endmodule

// File: rtl/base_vrfilt.sv
// Valid/ready filter stage: passes one valid/ready handshake through only while en is high.
module base_vrfilt (
    input  logic en,
    input  logic i_v,
    output logic i_r,
    output logic o_v,
    input  logic o_r
);

    assign o_v = i_v & en;
    assign i_r = o_r & en;

endmodule

// File: rtl/base_rrarb.sv
// Round-robin stream arbiter: shares one valid/ready channel among n requesters, locking across multi-beat transfers.
module base_rrarb
    import base_rrarb_pkg::*;
#(
    parameter int unsigned n     = 4,
    parameter int unsigned width = 64,
    parameter int unsigned idw   = clog2_min1(n)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic [n-1:0]       i_v,
    output logic [n-1:0]       i_r,
    input  logic [n*width-1:0] i_d,
    input  logic [n-1:0]       i_e,
    output logic               o_v,
    input  logic               o_r,
    output logic [width-1:0]   o_d,
    output logic               o_e,
    output logic [idw-1:0]     o_s
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [idw-1:0] r_ptr, w_ptr_nxt;
    logic [idw-1:0] r_lsel, w_lsel_nxt;

    logic [idw-1:0] w_pick_sel;
    logic           w_pick_any;
    logic [idw-1:0] w_sel;
    logic           w_en;
    logic           w_acc;
    logic [n-1:0]   w_fv;

    base_rrpick #(
        .n   (n),
        .idw (idw)
    ) u_pick (
        .i_ptr (r_ptr),
        .i_v   (i_v),
        .o_sel (w_pick_sel),
        .o_any (w_pick_any)
    );

    assign w_sel = (r_state == ST_LOCK) ? r_lsel : w_pick_sel;
    // Reset gates the enable so nothing handshakes while reset_n is low.
    assign w_en  = en & reset_n;

    for (genvar k = 0; k < n; k++) begin : g_filt
        base_vrfilt u_filt (
            .en  (w_en & (w_sel == idw'(k))),
            .i_v (i_v[k]),
            .i_r (i_r[k]),
            .o_v (w_fv[k]),
            .o_r (o_r)
        );
    end

    assign o_v = |w_fv;
    assign o_s = w_sel;

    always_comb begin
        o_d = '0;
        o_e = 1'b0;
        for (int unsigned k = 0; k < n; k++) begin
            if (w_sel == idw'(k)) begin
                o_d = i_d[k*width +: width];
                o_e = i_e[k];
            end
        end
    end

    assign w_acc = o_v & o_r & ((r_state == ST_LOCK) | w_pick_any);

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_lsel_nxt  = r_lsel;
        if (w_acc) begin
            case (r_state)
                ST_IDLE: begin
                    w_ptr_nxt = w_sel;
                    if (!o_e) begin
                        w_state_nxt = ST_LOCK;
                        w_lsel_nxt  = w_sel;
                    end
                end
                ST_LOCK: begin
                    if (o_e) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= idw'(n - 1);
            r_lsel  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_lsel  <= w_lsel_nxt;
        end
    end

endmodule

// File: doc/base_rrarb.md
# base_rrarb

Round-robin stream arbiter that shares one downstream valid/ready channel between `n` upstream requesters. It sequences the per-requester accept gating (the `en` of a valid/ready filter stage), so exactly one requester's valid/ready pair is connected through at a time. A grant locks for the duration of a multi-beat transfer and is released on the accepted end beat. It sits between the per-engine command/data sources and a shared AFU interface port.

## Interface
- `n`, 4: number of requesters, 2..16.
- `width`, 64: data width per requester.
- `idw`, $clog2(n): width of source-id output.

- `clk` in 1: single clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `en` in 1: global accept enable; 0 holds all transfers, with no state change.
- `i_v` in n: per-requester valid.
- `i_r` out n: per-requester ready.
- `i_d` in n*width: requester k data at bits [k*width +: width].
- `i_e` in n: per-requester end-of-transfer marker, qualified by `i_v`.
- `o_v` out 1: downstream valid.
- `o_r` in 1: downstream ready.
- `o_d` out width: muxed data.
- `o_e` out 1: muxed end marker.
- `o_s` out idw: index of the requester currently driving the output.

## Operation
- State: `ptr` (idw bits, the last-granted index), `lock` (1 bit), `lsel` (idw bits, the locked index).
- Select, when `lock`=0: `sel` is the first k with `i_v[k]`=1, scanning from `ptr+1` upward, wrapping modulo `n`.
  - `ptr` itself is checked last.
  - If no `i_v` is set, `sel`=`ptr` and `o_v`=0.
- Select, when `lock`=1: `sel`=`lsel`, regardless of other `i_v`.
- Outputs:
  - `o_v` = `i_v[sel]` & `en`.
  - `o_d` = `i_d[sel]`, `o_e` = `i_e[sel]`, `o_s` = `sel`.
  - `i_r[k]` = `o_r` & `en` & (k==`sel`); all other `i_r` bits are 0.
- Beat accept: `acc` = `o_v` & `o_r`.
- Transitions on `acc`:
  - `lock`=0, `o_e`=0: set `lock`=1, `lsel`=`sel`, `ptr`=`sel`.
  - `lock`=0, `o_e`=1: single-beat transfer; `lock` stays 0, `ptr`=`sel`.
  - `lock`=1, `o_e`=0: no change.
  - `lock`=1, `o_e`=1: set `lock`=0; `ptr` keeps `lsel`, so the next arbitration starts at `lsel+1`.
- No `acc`: no state change.
  - A valid requester that is never accepted does not move `ptr`.
  - In IDLE (`lock`=0), the selection may change between cycles when `i_v` changes. The requester, not the arbiter, must hold `i_v` until accepted.
- `en`=0 forces `o_v`=0 and all `i_r`=0. It does not release `lock`. A locked transfer resumes when `en` returns to 1.
- Locked requester drops `i_v` mid-transfer: the arbiter waits with `o_v`=0 and does not release. No other requester is granted until the end beat.
- Fairness: with all requesters continuously valid, single-beat grants rotate 0,1,...,n-1,0 after reset.

## Timing
- Zero cycle latency. `o_v`/`o_d`/`o_e`/`o_s`/`i_r` are combinational from inputs and registered state.
- State updates on the `clk` edge after `acc`.
- There is a combinational path `o_r`→`i_r`, matching the filter stage it controls. No `o_v`→`o_r` dependence.
- Reset values (asynchronous, immediate on `reset_n`=0):
  - `ptr`=n-1, so port 0 wins first.
  - `lock`=0, `lsel`=0.
- While `reset_n`=0, `o_v` and all `i_r` are forced to 0.
- Reset asserted mid-transfer: the lock is dropped. A partial transfer is abandoned, and the downstream side must be reset by the same `reset_n`.
- Throughput: one beat per cycle, including back-to-back end beats from different requesters with no idle cycle.

## Structure
- The package holds nothing block-specific. Only the shared `$clog2` helper is used.
- The rotating priority pick (`ptr`, `i_v` → `sel`, `any`) is one sub-module, `base_rrpick`, which is reusable by other arbiters.
- The per-port ready gating uses existing filter stage instances, one per requester, with `en` driven from the grant decode.

## Test plan
- Reset release with `i_v`=4'b1111, all `i_e`=1, `o_r`=1 → accepted `o_s` sequence 0,1,2,3,0. `i_r` is one-hot each cycle.
- Port 1 sends 3 beats (`i_e`=0,0,1) while ports 0 and 2 are valid → `o_s`=1 for exactly 3 accepted beats. Port 2 is granted next.
- Locked port 2 drops `i_v` for 2 cycles mid-transfer while port 3 is valid → `o_v`=0 for those cycles, `i_r[3]`=0, and port 2 resumes.
- `en`=0 for 4 cycles during a locked transfer with `o_r`=1 → no accepts and `i_r`=0. Transfer continues on the same port after `en`=1.
- `o_r`=0 with port 3 valid, then `i_v[0]` rises → `ptr` is unchanged. Selection follows the round-robin order from `ptr`.
- Assert `reset_n`=0 mid-transfer on port 2 → `o_v`=0 immediately. After release, with ports 1 and 2 valid, port 1 is granted.
